// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer: FSM states,
// bus source codes and the bit layout of the ctrlsig strobe vector.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOAD = 3'd4,
    ST_NEXT = 3'd5,
    ST_JMP  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_IR   = 3'd2,
    BUS_AR   = 3'd3,
    BUS_DR   = 3'd4,
    BUS_TR   = 3'd5,
    BUS_IRAM = 3'd6,
    BUS_WTA  = 3'd7
  } bus_sel_e;

  localparam int CS_PC_WE   = 0;
  localparam int CS_PC_INC  = 1;
  localparam int CS_PC_RST  = 2;
  localparam int CS_IRAM_RE = 3;
  localparam int CS_DR_WE   = 4;
  localparam int CS_W       = 5;

  // Wide enough for the largest extra-wait preset (WAIT_CYC-1 = 2).
  localparam int WAIT_CNT_W = 2;

  function automatic logic [WAIT_CNT_W-1:0] wait_preset(input int wait_cyc);
    return WAIT_CNT_W'(wait_cyc - 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between a host and the fetch sequencer.
// The host drives the request inputs (master); the sequencer drives the strobes (slave).
interface fetch_sequencer_if #(
  parameter int CNT_W = 8
);
  import fetch_sequencer_pkg::*;

  logic             start;
  logic             clear;
  logic             jump;
  logic             halt_req;
  logic             pc_write_en;
  logic             pc_inc;
  logic             pc_reset;
  logic             iram_read_en;
  logic             dr_write_en;
  logic [CS_W-1:0]  ctrlsig;
  logic [2:0]       bus_sel;
  logic             busy;
  logic             fetch_done;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output start, clear, jump, halt_req,
    input  pc_write_en, pc_inc, pc_reset, iram_read_en, dr_write_en,
    input  ctrlsig, bus_sel, busy, fetch_done, fetch_count
  );

  modport slave (
    input  start, clear, jump, halt_req,
    output pc_write_en, pc_inc, pc_reset, iram_read_en, dr_write_en,
    output ctrlsig, bus_sel, busy, fetch_done, fetch_count
  );

endinterface

// File: rtl/seq_wait_counter.sv
// Down-counter that stretches the WAIT state to cover the IRAM read latency.
// Preset while the sequencer sits in ADDR; done when it reaches zero.
module seq_wait_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int WAIT_CYC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = wait_preset(WAIT_CYC);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks ADDR/WAIT/LOAD/NEXT to pull one word from
// IRAM into DR, then advances or reloads the PC. All outputs decode the registered state.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int WAIT_CYC = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave fs
);

  state_e           state_q;
  state_e           state_d;
  logic             jump_lat_q;
  logic             jump_lat_d;
  logic             halt_lat_q;
  logic             halt_lat_d;
  logic [CNT_W-1:0] fetch_count_q;
  logic [CNT_W-1:0] fetch_count_d;
  logic             wait_load;
  logic             wait_dec;
  logic             wait_done;
  logic             in_fetch;
  logic [CS_W-1:0]  ctrl;
  bus_sel_e         bus_sel;
  logic             fetch_done;

  assign wait_load = (state_q == ST_ADDR);
  assign wait_dec  = (state_q == ST_WAIT);

  seq_wait_counter #(
    .WAIT_CYC (WAIT_CYC)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (wait_load),
    .dec   (wait_dec),
    .done  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      jump_lat_q    <= 1'b0;
      halt_lat_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      jump_lat_q    <= jump_lat_d;
      halt_lat_q    <= halt_lat_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fs.start) begin
          state_d = fs.clear ? ST_CLR : ST_ADDR;
        end
      end
      ST_CLR:  state_d = ST_ADDR;
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_done) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_NEXT;
      // A pending jump always gets its PC load before a latched halt is honoured.
      ST_NEXT: begin
        if (jump_lat_q) begin
          state_d = ST_JMP;
        end else if (halt_lat_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_JMP:  state_d = halt_lat_q ? ST_IDLE : ST_ADDR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Requests stick from ADDR through LOAD and are dropped once the fetch retires.
  assign in_fetch = (state_q == ST_ADDR) || (state_q == ST_WAIT) || (state_q == ST_LOAD);

  always_comb begin
    jump_lat_d    = jump_lat_q;
    halt_lat_d    = halt_lat_q;
    fetch_count_d = fetch_count_q;
    if (in_fetch) begin
      jump_lat_d = jump_lat_q | fs.jump;
      halt_lat_d = halt_lat_q | fs.halt_req;
    end
    if (state_q == ST_NEXT) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
      if (state_d != ST_JMP) begin
        jump_lat_d = 1'b0;
        halt_lat_d = 1'b0;
      end
    end
    if (state_q == ST_JMP) begin
      jump_lat_d = 1'b0;
      halt_lat_d = 1'b0;
    end
  end

  always_comb begin
    ctrl       = '0;
    bus_sel    = BUS_NONE;
    fetch_done = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_CLR:  ctrl[CS_PC_RST] = 1'b1;
      ST_ADDR: ctrl[CS_IRAM_RE] = 1'b1;
      ST_WAIT: begin
        ctrl[CS_IRAM_RE] = 1'b1;
        bus_sel          = BUS_IRAM;
      end
      ST_LOAD: begin
        ctrl[CS_IRAM_RE] = 1'b1;
        ctrl[CS_DR_WE]   = 1'b1;
        bus_sel          = BUS_IRAM;
      end
      ST_NEXT: begin
        fetch_done      = 1'b1;
        ctrl[CS_PC_INC] = ~jump_lat_q;
      end
      ST_JMP:  ctrl[CS_PC_WE] = 1'b1;
      default: ;
    endcase
  end

  assign fs.ctrlsig      = ctrl;
  assign fs.pc_write_en  = ctrl[CS_PC_WE];
  assign fs.pc_inc       = ctrl[CS_PC_INC];
  assign fs.pc_reset     = ctrl[CS_PC_RST];
  assign fs.iram_read_en = ctrl[CS_IRAM_RE];
  assign fs.dr_write_en  = ctrl[CS_DR_WE];
  assign fs.bus_sel      = bus_sel;
  assign fs.busy         = (state_q != ST_IDLE);
  assign fs.fetch_done   = fetch_done;
  assign fs.fetch_count  = fetch_count_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter WAIT_CYC, default 1, is the number of IRAM read-latency cycles between the iram_read_en assertion and data valid on the bus; legal range 1..3.
REQ-002 Parameter CNT_W, default 8, is the width of fetch_count.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to begin fetching; sampled only in IDLE.
REQ-006 clear  in  1  with start, zero the PC before the first fetch.
REQ-007 jump  in  1  load the PC from the external datain instead of incrementing, at the end of the current fetch.
REQ-008 halt_req  in  1  stop after the current fetch completes.
REQ-009 pc_write_en  out  1  drives PC write_en (ctrlsig[0]).
REQ-010 pc_inc  out  1  drives PC inc (ctrlsig[1]).
REQ-011 pc_reset  out  1  drives PC reset (ctrlsig[2]).
REQ-012 iram_read_en  out  1  drives IRAM read_en (ctrlsig[3]).
REQ-013 dr_write_en  out  1  drives DR write_en (ctrlsig[4]).
REQ-014 bus_sel  out  3  bus source: 0 none, 1 PC, 2 IR, 3 AR, 4 DR, 5 TR, 6 IRAM, 7 WTA.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 fetch_done  out  1  one-cycle pulse per completed fetch.
REQ-017 fetch_count  out  CNT_W  number of completed fetches since reset, wrapping.

Function
REQ-018 States: IDLE, CLR, ADDR, WAIT, LOAD, NEXT, JMP. All outputs are Moore-decoded from the registered state, with no input-to-output combinational path.
REQ-019 IDLE transitions: if start and clear, go to CLR; if start only, go to ADDR; otherwise stay. All strobes are 0 and bus_sel is 0.
REQ-020 CLR: pc_reset=1 for exactly 1 cycle, then go to ADDR.
REQ-021 ADDR: iram_read_en=1 and bus_sel=0 for 1 cycle, then go to WAIT.
REQ-022 WAIT: iram_read_en=1 and bus_sel=6. The state holds WAIT_CYC-1 further cycles, with WAIT_CYC=1 giving 0 extra cycles and direct passage through, then goes to LOAD.
REQ-023 LOAD: bus_sel=6, dr_write_en=1, iram_read_en=1 for 1 cycle, then go to NEXT.
REQ-024 NEXT: fetch_done=1 and fetch_count increments. The PC update depends on the jump latched during the fetch:
  - jump latched: go to JMP with pc_inc=0.
  - jump not latched: pc_inc=1 this cycle, then go to ADDR.
  - halt latched: go to IDLE, overriding the above, but pc_inc/JMP still apply first.
REQ-025 JMP: pc_write_en=1 for 1 cycle, then go to ADDR, or to IDLE if halt is latched.
REQ-026 jump and halt_req are sticky-latched on any cycle from ADDR through LOAD and cleared on leaving NEXT/JMP. They are ignored in IDLE.
REQ-027 Fetch latency from ADDR entry to fetch_done is WAIT_CYC+2 cycles. With the default this is 3 cycles, giving 4 cycles per fetch without a jump.
REQ-028 At most one of pc_write_en, pc_inc, pc_reset is high in any cycle.
REQ-029 fetch_count wraps from 2^CNT_W-1 to 0 without a flag.
REQ-030 Simultaneous jump and halt_req: the PC is loaded (JMP), then the block goes to IDLE.
REQ-031 start asserted while busy is ignored and is not queued.

Reset
REQ-032 When reset=1 on a clock edge, state becomes IDLE, all strobes become 0, bus_sel becomes 0, busy becomes 0, fetch_done becomes 0, fetch_count becomes 0, and the latches are cleared. Reset takes priority over all inputs.
REQ-033 Reset mid-fetch aborts the fetch with no fetch_done or count increment, and no strobe is seen the following cycle.

Structure
REQ-034 The shared package holds the state enum, the bus_sel source codes (0..7), and the ctrlsig bit positions (0..4).
REQ-035 One sub-module, seq_wait_counter, is the WAIT-state latency down-counter.
REQ-036 The top-level exposes {dr_write_en, iram_read_en, pc_reset, pc_inc, pc_write_en} in ctrlsig[4:0] order.

Verification
REQ-037 Reset then start=1 for 1 cycle with WAIT_CYC=1 -> iram_read_en high cycles 1-3, dr_write_en and bus_sel=6 at cycle 3, fetch_done and pc_inc at cycle 4, ADDR re-entered at cycle 5.
REQ-038 start with clear=1 -> pc_reset=1 exactly 1 cycle before the first iram_read_en; fetch_count=1 after the first fetch.
REQ-039 jump=1 pulsed during WAIT -> NEXT has pc_inc=0, next cycle pc_write_en=1, then ADDR.
REQ-040 halt_req and jump both pulsed in ADDR -> pc_write_en once, then IDLE, busy=0; a later start resumes.
REQ-041 reset asserted in LOAD -> next cycle all strobes 0, fetch_count unchanged at its prior value only if the increment had not occurred (it must not increment), state IDLE.
REQ-042 Run 256 fetches with CNT_W=8, WAIT_CYC=3 -> fetch_count wraps to 0; each fetch takes 6 cycles; the one-hot PC strobe check holds throughout.
